// File: rtl/irq_controller.sv
// irq_controller: 16-source edge-latched interrupt controller, 8 priority groups.
// Ports: clk, reset (async low), bus_* register port, irq_in, cpu_ilevel, irq_ack -> irq_req/source/level.
module irq_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [15:0] irq_in,
  input  logic [1:0]  cpu_ilevel,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [3:0]  irq_source,
  output logic [1:0]  irq_level
);

  localparam logic [23:0] A_PRIO_LO = 24'h002020;
  localparam logic [23:0] A_PRIO_HI = 24'h002021;
  localparam logic [23:0] A_EN_LO   = 24'h002023;
  localparam logic [23:0] A_EN_HI   = 24'h002024;
  localparam logic [23:0] A_FLG_LO  = 24'h002027;
  localparam logic [23:0] A_FLG_HI  = 24'h002028;

  logic [15:0] prio;
  logic [15:0] enable;
  logic [15:0] flag;
  logic [15:0] prev;

  logic        unused_read;
  assign unused_read = bus_read;

  logic wr_prio_lo, wr_prio_hi;
  logic wr_en_lo, wr_en_hi;
  logic wr_flg_lo, wr_flg_hi;

  assign wr_prio_lo = bus_write && (bus_address_in == A_PRIO_LO);
  assign wr_prio_hi = bus_write && (bus_address_in == A_PRIO_HI);
  assign wr_en_lo   = bus_write && (bus_address_in == A_EN_LO);
  assign wr_en_hi   = bus_write && (bus_address_in == A_EN_HI);
  assign wr_flg_lo  = bus_write && (bus_address_in == A_FLG_LO);
  assign wr_flg_hi  = bus_write && (bus_address_in == A_FLG_HI);

  logic        ack_hit;
  logic [15:0] set_edge;
  logic [15:0] clr_bus;
  logic [15:0] clr_ack;
  logic [15:0] flag_nxt;

  assign ack_hit  = irq_ack && irq_req;
  assign set_edge = irq_in & ~prev;
  assign clr_bus  = {wr_flg_hi ? bus_data_in : 8'h00,
                     wr_flg_lo ? bus_data_in : 8'h00};
  assign clr_ack  = ack_hit ? (16'h0001 << irq_source) : 16'h0000;
  // A fresh edge outranks any clear on the same bit.
  assign flag_nxt = (flag & ~(clr_bus | clr_ack)) | set_edge;

  logic [1:0]  src_prio [16];
  logic [15:0] elig;

  for (genvar g = 0; g < 16; g++) begin : g_src
    assign src_prio[g] = prio[2*(g/2) +: 2];
    assign elig[g] = flag[g] & enable[g] &
                     (src_prio[g] != 2'd0) &
                     (src_prio[g] > cpu_ilevel);
  end

  logic       win_found;
  logic [3:0] win_idx;
  logic [1:0] win_lvl;

  // Strict '>' while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    win_lvl   = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (elig[i] && (src_prio[i] > win_lvl)) begin
        win_found = 1'b1;
        win_idx   = i[3:0];
        win_lvl   = src_prio[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio       <= '0;
      enable     <= '0;
      flag       <= '0;
      prev       <= '0;
      irq_req    <= 1'b0;
      irq_source <= 4'd0;
      irq_level  <= 2'd0;
    end else begin
      prev <= irq_in;
      flag <= flag_nxt;
      if (wr_prio_lo) prio[7:0]    <= bus_data_in;
      if (wr_prio_hi) prio[15:8]   <= bus_data_in;
      if (wr_en_lo)   enable[7:0]  <= bus_data_in;
      if (wr_en_hi)   enable[15:8] <= bus_data_in;
      // The ack'd flag is still visible to this cycle's arbitration,
      // so the request is forced low for one cycle.
      if (ack_hit) begin
        irq_req <= 1'b0;
      end else begin
        irq_req <= win_found;
        if (win_found) begin
          irq_source <= win_idx;
          irq_level  <= win_lvl;
        end
      end
    end
  end

  always_comb begin
    case (bus_address_in)
      A_PRIO_LO: bus_data_out = prio[7:0];
      A_PRIO_HI: bus_data_out = prio[15:8];
      A_EN_LO:   bus_data_out = enable[7:0];
      A_EN_HI:   bus_data_out = enable[15:8];
      A_FLG_LO:  bus_data_out = flag[7:0];
      A_FLG_HI:  bus_data_out = flag[15:8];
      default:   bus_data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table-driven directed checks for irq_controller
// plus hand sequences for clear race, level hold and async reset.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [15:0] irq_in;
  logic [1:0]  cpu_ilevel;
  logic        irq_ack;
  logic        irq_req;
  logic [3:0]  irq_source;
  logic [1:0]  irq_level;

  int n_total = 0;
  int n_pass  = 0;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_in         (irq_in),
    .cpu_ilevel     (cpu_ilevel),
    .irq_ack        (irq_ack),
    .irq_req        (irq_req),
    .irq_source     (irq_source),
    .irq_level      (irq_level)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [15:0] irq;
    logic [1:0]  il;
    logic        ack;
    logic        e_req;
    logic [3:0]  e_src;
    logic [1:0]  e_lvl;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [23:0] a,
                    input logic [7:0] exp);
    bus_address_in = a;
    #1;
    chk(name, {8'h00, bus_data_out}, {8'h00, exp});
  endtask

  initial begin
    reset = 1'b0;
    bus_write = 1'b0;
    bus_read = 1'b0;
    bus_address_in = 24'h0;
    bus_data_in = 8'h0;
    irq_in = 16'h0;
    cpu_ilevel = 2'd0;
    irq_ack = 1'b0;

    // wr addr wdata irq il ack | req src lvl rd
    vt.push_back('{1'b1, 24'h002021, 8'h02, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h02});
    vt.push_back('{1'b1, 24'h002024, 8'h01, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h01});
    vt.push_back('{1'b1, 24'h002020, 8'h04, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h04});
    vt.push_back('{1'b1, 24'h002023, 8'h0C, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h0C});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h01});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b1, 4'd8, 2'd2, 8'h01});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd8, 2'd2, 8'h00});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd8, 2'd2, 8'h00});
    vt.push_back('{1'b1, 24'h002021, 8'h03, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd8, 2'd2, 8'h03});
    vt.push_back('{1'b0, 24'h002027, 8'h00, 16'h010C, 2'd0, 1'b0, 1'b0, 4'd8, 2'd2, 8'h0C});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b1, 4'd8, 2'd3, 8'h01});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd8, 2'd3, 8'h00});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b1, 4'd2, 2'd1, 8'h00});
    vt.push_back('{1'b0, 24'h002027, 8'h00, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd2, 2'd1, 8'h08});
    vt.push_back('{1'b0, 24'h002027, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b1, 4'd3, 2'd1, 8'h08});
    vt.push_back('{1'b0, 24'h002027, 8'h00, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd3, 2'd1, 8'h00});
    vt.push_back('{1'b0, 24'h002027, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd3, 2'd1, 8'h00});
    vt.push_back('{1'b1, 24'h002021, 8'h02, 16'h0100, 2'd2, 1'b0, 1'b0, 4'd3, 2'd1, 8'h02});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd2, 1'b0, 1'b0, 4'd3, 2'd1, 8'h01});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd2, 1'b0, 1'b0, 4'd3, 2'd1, 8'h01});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd1, 1'b0, 1'b1, 4'd8, 2'd2, 8'h01});
    vt.push_back('{1'b1, 24'h002024, 8'h00, 16'h0000, 2'd1, 1'b0, 1'b1, 4'd8, 2'd2, 8'h00});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd1, 1'b0, 1'b0, 4'd8, 2'd2, 8'h01});
    vt.push_back('{1'b1, 24'h002024, 8'h01, 16'h0000, 2'd1, 1'b0, 1'b0, 4'd8, 2'd2, 8'h01});
    vt.push_back('{1'b0, 24'h002024, 8'h00, 16'h0000, 2'd1, 1'b0, 1'b1, 4'd8, 2'd2, 8'h01});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd8, 2'd2, 8'h00});
    vt.push_back('{1'b0, 24'h002028, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd8, 2'd2, 8'h00});

    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst req", {15'h0, irq_req}, 16'h0);
    chk("rst src", {12'h0, irq_source}, 16'h0);
    chk("rst lvl", {14'h0, irq_level}, 16'h0);
    rd("rst 2020", 24'h002020, 8'h00);
    rd("rst 2024", 24'h002024, 8'h00);
    rd("rst 2028", 24'h002028, 8'h00);

    bus_write = 1'b1;
    bus_address_in = 24'h002022;
    bus_data_in = 8'hFF;
    tick();
    bus_write = 1'b0;
    rd("unmapped 2022", 24'h002022, 8'h00);

    foreach (vt[i]) begin
      bus_write      = vt[i].wr;
      bus_address_in = vt[i].addr;
      bus_data_in    = vt[i].wdata;
      irq_in         = vt[i].irq;
      cpu_ilevel     = vt[i].il;
      irq_ack        = vt[i].ack;
      tick();
      chk($sformatf("v%0d req", i), {15'h0, irq_req}, {15'h0, vt[i].e_req});
      chk($sformatf("v%0d src", i), {12'h0, irq_source}, {12'h0, vt[i].e_src});
      chk($sformatf("v%0d lvl", i), {14'h0, irq_level}, {14'h0, vt[i].e_lvl});
      chk($sformatf("v%0d rd", i), {8'h0, bus_data_out}, {8'h0, vt[i].e_rd});
    end
    bus_write = 1'b0;
    irq_ack = 1'b0;
    irq_in = 16'h0;
    cpu_ilevel = 2'd0;

    // Clear race: W1C of all low flags against a new edge on bit 0.
    irq_in = 16'h0006;
    tick();
    irq_in = 16'h0000;
    tick();
    rd("race pre", 24'h002027, 8'h06);
    bus_write = 1'b1;
    bus_data_in = 8'hFF;
    irq_in = 16'h0001;
    tick();
    bus_write = 1'b0;
    rd("race post", 24'h002027, 8'h01);
    irq_in = 16'h0000;
    bus_write = 1'b1;
    bus_data_in = 8'h01;
    tick();
    bus_write = 1'b0;
    rd("race clr", 24'h002027, 8'h00);

    // Level hold: one flag only; a clear during the hold sticks.
    irq_in = 16'h0020;
    tick();
    rd("hold set", 24'h002027, 8'h20);
    for (int c = 1; c < 20; c++) begin
      if (c == 10) begin
        bus_write = 1'b1;
        bus_data_in = 8'h20;
      end
      tick();
      bus_write = 1'b0;
      if (c == 9) rd("hold mid", 24'h002027, 8'h20);
    end
    rd("hold end lo", 24'h002027, 8'h00);
    rd("hold end hi", 24'h002028, 8'h00);
    irq_in = 16'h0000;
    tick();

    // Async reset mid-cycle with a request and an ack pending.
    irq_in = 16'h0100;
    tick();
    irq_in = 16'h0000;
    tick();
    chk("pre-rst req", {15'h0, irq_req}, 16'h0001);
    chk("pre-rst src", {12'h0, irq_source}, 16'h0008);
    irq_ack = 1'b1;
    #4;
    reset = 1'b0;
    #1;
    chk("arst req", {15'h0, irq_req}, 16'h0);
    chk("arst src", {12'h0, irq_source}, 16'h0);
    chk("arst lvl", {14'h0, irq_level}, 16'h0);
    rd("arst 2021", 24'h002021, 8'h00);
    rd("arst 2024", 24'h002024, 8'h00);
    rd("arst 2028", 24'h002028, 8'h00);
    tick();
    irq_ack = 1'b0;
    irq_in = 16'h0100;
    #3;
    reset = 1'b1;
    tick();
    rd("rel flag", 24'h002028, 8'h01);
    chk("rel req0", {15'h0, irq_req}, 16'h0);
    tick();
    chk("rel req1", {15'h0, irq_req}, 16'h0);
    irq_in = 16'h0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
